// File: rtl/bob_ring.sv
// -----------------------------------------------------------------------------
// bob_ring -- branch order buffer organised as a circular queue.
//
// Holds up to DEPTH in-flight branch entries in program order. New entries are
// inserted at the tail (wptr) and retired from the head (rptr). A misprediction
// rewinds the tail to just past the mispredicted branch, squashing every
// younger entry. A flush discards everything. All DEPTH slots are usable; a
// separate count register tells "full" apart from "empty" when the pointers
// coincide.
//
// Ports
//   clock, reset_n            single rising-edge clock, async active-low reset
//   flush_i                   synchronous discard of all entries (top priority)
//   alloc_i, alloc_data_i     insert one entry at the tail
//   alloc_tag_o               slot index the next accepted alloc receives
//   alloc_ok_o                alloc accepted this cycle (combinational)
//   retire_i                  remove the head entry
//   rewind_i, rewind_tag_i    squash entries younger than rewind_tag_i
//   head_data_o, head_tag_o   payload / slot index of the oldest entry
//   head_valid_o              buffer non-empty
//   count_o                   number of valid entries, 0..DEPTH
//   full_o, empty_o           count_o == DEPTH / count_o == 0
//
// full_o, empty_o, head_valid_o and count_o depend on registered state only.
// -----------------------------------------------------------------------------
module bob_ring #(
  parameter int DATAWIDTH = 93,
  parameter int DEPTH     = 16,
  parameter int LOGDEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush_i,
  input  logic                 alloc_i,
  input  logic [DATAWIDTH-1:0] alloc_data_i,
  output logic [LOGDEPTH-1:0]  alloc_tag_o,
  output logic                 alloc_ok_o,
  input  logic                 retire_i,
  input  logic                 rewind_i,
  input  logic [LOGDEPTH-1:0]  rewind_tag_i,
  output logic [DATAWIDTH-1:0] head_data_o,
  output logic [LOGDEPTH-1:0]  head_tag_o,
  output logic                 head_valid_o,
  output logic [LOGDEPTH:0]    count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  typedef logic [LOGDEPTH-1:0] ptr_t;
  typedef logic [LOGDEPTH:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam ptr_t PTR_ONE   = ptr_t'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] storage [DEPTH];
  logic [DEPTH-1:0]     valid;
  ptr_t                 rptr;
  ptr_t                 wptr;
  cnt_t                 count;

  logic [DEPTH-1:0]     valid_nxt;
  ptr_t                 rptr_nxt;
  ptr_t                 wptr_nxt;
  cnt_t                 count_nxt;
  ptr_t                 ptr_diff_nxt;

  logic                 alloc_acc;
  logic                 retire_acc;
  logic                 rewind_acc;
  ptr_t                 rewind_dist;

  // ---------------------------------------------------------------------------
  // Status, derived from registered state only
  // ---------------------------------------------------------------------------
  assign full_o       = (count == DEPTH_CNT);
  assign empty_o      = (count == '0);
  assign head_valid_o = ~empty_o;
  assign count_o      = count;

  assign alloc_tag_o  = wptr;
  assign head_tag_o   = rptr;
  assign head_data_o  = storage[rptr];

  // ---------------------------------------------------------------------------
  // Request acceptance. A rewind request (valid or not) blocks alloc so the
  // tail is never moved by two sources in the same cycle.
  // ---------------------------------------------------------------------------
  assign alloc_acc  = alloc_i & ~full_o & ~flush_i & ~rewind_i;
  assign retire_acc = retire_i & head_valid_o & ~flush_i;
  assign rewind_acc = rewind_i & valid[rewind_tag_i] & ~flush_i;
  assign alloc_ok_o = alloc_acc;

  // Age of the rewind target measured from the head; any slot further from the
  // head than this is younger and gets squashed.
  assign rewind_dist = rewind_tag_i - rptr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_nxt    = valid;
    rptr_nxt     = rptr;
    wptr_nxt     = wptr;
    count_nxt    = count;
    ptr_diff_nxt = '0;

    if (flush_i) begin
      valid_nxt = '0;
      rptr_nxt  = '0;
      wptr_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (rewind_acc) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ptr_t'(ptr_t'(i) - rptr) > rewind_dist) begin
            valid_nxt[i] = 1'b0;
          end
        end
        wptr_nxt = rewind_tag_i + PTR_ONE;
      end else if (alloc_acc) begin
        valid_nxt[wptr] = 1'b1;
        wptr_nxt        = wptr + PTR_ONE;
      end

      // Retire is independent of the tail update; with rewind_tag_i == rptr
      // the surviving entry is retired and the buffer drains to empty.
      if (retire_acc) begin
        valid_nxt[rptr] = 1'b0;
        rptr_nxt        = rptr + PTR_ONE;
      end

      // Pointer difference gives the occupancy except when the pointers meet,
      // where the buffer is either completely full or empty. Slots outside the
      // live window are always invalid, so the head slot's valid bit decides.
      ptr_diff_nxt = wptr_nxt - rptr_nxt;
      if (ptr_diff_nxt == '0 && valid_nxt[rptr_nxt]) begin
        count_nxt = DEPTH_CNT;
      end else begin
        count_nxt = cnt_t'(ptr_diff_nxt);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      valid <= valid_nxt;
      rptr  <= rptr_nxt;
      wptr  <= wptr_nxt;
      count <= count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage. Flush and rewind leave payloads in place; only the valid
  // bits and pointers decide what is live.
  // ---------------------------------------------------------------------------
  // NOTE: the payload array is deliberately reset so head_data_o reads zero
  // after reset; this costs a reset net on every storage flop and prevents
  // mapping the array onto RAM macros.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (alloc_acc) begin
      storage[wptr] <= alloc_data_i;
    end
  end

endmodule
